seq_alu: RTL and testbench

- Parametrised, multi-cycle successor to the combinational ALU.
- Width is set by DATA_WIDTH. Operands and opcode are latched on a START/DONE handshake.
- Logic and shift operations complete in 1 cycle. Multiply and divide use a shared iterative unit and produce a double-width HI/LO result.
- Sits in the execute stage. The control unit holds the pipeline while BUSY=1.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/seq_alu_muldiv.sv | 101 ++++++++++
 rtl/seq_alu.sv | 194 +++++++++++++++++++
 tb/tb_seq_alu.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode map, FSM state
// encoding and the opcode classifier used by the control logic.
package alu_pkg;

   // Width of the architected opcode field; wider OPRN ports must carry
   // zeros above this width to decode as a valid operation.
   localparam int OPCODE_W = 6;

   localparam logic [OPCODE_W-1:0] OPRN_ADD  = 6'h01;
   localparam logic [OPCODE_W-1:0] OPRN_SUB  = 6'h02;
   localparam logic [OPCODE_W-1:0] OPRN_MULU = 6'h03;
   localparam logic [OPCODE_W-1:0] OPRN_SRL  = 6'h04;
   localparam logic [OPCODE_W-1:0] OPRN_SLL  = 6'h05;
   localparam logic [OPCODE_W-1:0] OPRN_AND  = 6'h06;
   localparam logic [OPCODE_W-1:0] OPRN_OR   = 6'h07;
   localparam logic [OPCODE_W-1:0] OPRN_NOR  = 6'h08;
   localparam logic [OPCODE_W-1:0] OPRN_SLT  = 6'h09;
   localparam logic [OPCODE_W-1:0] OPRN_SLTU = 6'h0A;
   localparam logic [OPCODE_W-1:0] OPRN_DIVU = 6'h0B;
   localparam logic [OPCODE_W-1:0] OPRN_SRA  = 6'h0C;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIN  = 2'd2
   } alu_state_t;

   // True for opcodes that run on the shared iterative MUL/DIV unit.
   function automatic logic is_multicycle(input logic [OPCODE_W-1:0] oprn);
      logic mc;
      case (oprn)
         OPRN_MULU, OPRN_DIVU: mc = 1'b1;
         default:              mc = 1'b0;
      endcase
      return mc;
   endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned multiply / restoring divide datapath.
// MUL: shift-add on a {hi,lo} accumulator, lo starts as the multiplier.
// DIV: shift-subtract, lo starts as the dividend and collects quotient bits,
//      hi collects the partial remainder.
// The load cycle already performs the first iteration on the incoming
// operands, so W-1 further step cycles complete the operation.
module seq_alu_muldiv
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
)(
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  load,
   input  logic                  step,
   input  logic                  is_div,
   input  logic [DATA_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] B,
   output logic [DATA_WIDTH-1:0] hi,
   output logic [DATA_WIDTH-1:0] lo
);

   localparam int W = DATA_WIDTH;

   logic [W-1:0] hi_r;
   logic [W-1:0] lo_r;
   logic [W-1:0] opnd_r;      // multiplicand or divisor
   logic         div_r;

   logic [W-1:0] cur_hi_s;
   logic [W-1:0] cur_lo_s;
   logic [W-1:0] cur_opnd_s;
   logic         cur_div_s;

   logic [W:0]   mul_sum_s;
   logic [W:0]   div_shift_s;
   logic         div_ge_s;
   logic [W-1:0] div_rem_s;

   logic [W-1:0] nxt_hi_s;
   logic [W-1:0] nxt_lo_s;

   // Iteration source: fresh operands on load, the accumulator afterwards.
   always_comb begin
      if (load) begin
         cur_hi_s   = {W{1'b0}};
         cur_lo_s   = is_div ? A : B;
         cur_opnd_s = is_div ? B : A;
         cur_div_s  = is_div;
      end else begin
         cur_hi_s   = hi_r;
         cur_lo_s   = lo_r;
         cur_opnd_s = opnd_r;
         cur_div_s  = div_r;
      end
   end

   // One shift-add (MUL) or shift-subtract (DIV) iteration.
   always_comb begin
      mul_sum_s   = {1'b0, cur_hi_s} + (cur_lo_s[0] ? {1'b0, cur_opnd_s} : {(W+1){1'b0}});
      div_shift_s = {cur_hi_s, cur_lo_s[W-1]};
      div_ge_s    = (div_shift_s >= {1'b0, cur_opnd_s});
      // When div_ge_s holds the difference is below the divisor, so it fits W bits.
      div_rem_s   = div_shift_s[W-1:0] - cur_opnd_s;
      if (cur_div_s) begin
         if (div_ge_s) begin
            nxt_hi_s = div_rem_s;
            nxt_lo_s = {cur_lo_s[W-2:0], 1'b1};
         end else begin
            nxt_hi_s = div_shift_s[W-1:0];
            nxt_lo_s = {cur_lo_s[W-2:0], 1'b0};
         end
      end else begin
         nxt_hi_s = mul_sum_s[W:1];
         nxt_lo_s = {mul_sum_s[0], cur_lo_s[W-1:1]};
      end
   end

   // Accumulator and latched operand registers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         hi_r   <= {W{1'b0}};
         lo_r   <= {W{1'b0}};
         opnd_r <= {W{1'b0}};
         div_r  <= 1'b0;
      end else begin
         if (load || step) begin
            hi_r <= nxt_hi_s;
            lo_r <= nxt_lo_s;
         end
         if (load) begin
            opnd_r <= cur_opnd_s;
            div_r  <= cur_div_s;
         end
      end
   end

   assign hi = hi_r;
   assign lo = lo_r;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle execute-stage ALU. Logic, add/sub, compare and shift ops
// complete in one cycle; MULU/DIVU run on the iterative unit and return a
// double-width HI/LO result. Operands are taken on START in IDLE and the
// result is announced with a one-cycle DONE pulse.
module seq_alu
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int OPRN_WIDTH = 6,
   parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
)(
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  START,
   input  logic [OPRN_WIDTH-1:0] OPRN,
   input  logic [DATA_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] B,
   output logic [DATA_WIDTH-1:0] Y,
   output logic [DATA_WIDTH-1:0] HI,
   output logic                  ZERO,
   output logic                  BUSY,
   output logic                  DONE,
   output logic                  ERR
);

   localparam int W = DATA_WIDTH;

   alu_state_t           state_r;
   logic [CNT_WIDTH-1:0] cnt_r;
   logic [W-1:0]         y_r;
   logic [W-1:0]         hi_r;
   logic                 zero_r;
   logic                 busy_r;
   logic                 done_r;
   logic                 err_r;

   logic [OPCODE_W-1:0]  op_s;
   logic                 op_fits_s;
   logic                 b_zero_s;
   logic                 shamt_big_s;
   logic [CNT_WIDTH-2:0] shamt_s;
   logic signed [W-1:0]  a_sgn_s;
   logic signed [W-1:0]  sra_s;
   logic                 slt_s;
   logic                 sltu_s;
   logic                 go_iter_s;
   logic [CNT_WIDTH-1:0] cnt_nxt_s;

   logic [W-1:0]         sc_y_s;
   logic [W-1:0]         sc_hi_s;
   logic                 sc_err_s;

   logic                 md_load_s;
   logic                 md_step_s;
   logic                 md_is_div_s;
   logic [W-1:0]         md_hi_s;
   logic [W-1:0]         md_lo_s;

   // Opcode decode, operand classification and shift/compare helpers.
   always_comb begin
      op_s        = OPCODE_W'(OPRN);
      // Bits of a wider opcode port above the architected field must be zero.
      op_fits_s   = (OPRN_WIDTH'(op_s) == OPRN);
      b_zero_s    = (B == {W{1'b0}});
      // Any shift amount of W or more empties (or sign-fills) the word.
      shamt_big_s = (B > W'(W - 1));
      shamt_s     = B[CNT_WIDTH-2:0];
      a_sgn_s     = A;
      sra_s       = a_sgn_s >>> shamt_s;
      slt_s       = ($signed(A) < $signed(B));
      sltu_s      = (A < B);
      go_iter_s   = op_fits_s && is_multicycle(op_s) && !((op_s == OPRN_DIVU) && b_zero_s);
      cnt_nxt_s   = cnt_r + CNT_WIDTH'(1);
   end

   // Single-cycle result, including the DIVU-by-zero and invalid-opcode paths.
   always_comb begin
      sc_y_s   = {W{1'b0}};
      sc_hi_s  = {W{1'b0}};
      sc_err_s = 1'b0;
      if (!op_fits_s) begin
         sc_err_s = 1'b1;
      end else begin
         case (op_s)
            OPRN_ADD:  sc_y_s = A + B;
            OPRN_SUB:  sc_y_s = A - B;
            OPRN_SRL:  sc_y_s = shamt_big_s ? {W{1'b0}} : (A >> shamt_s);
            OPRN_SLL:  sc_y_s = shamt_big_s ? {W{1'b0}} : (A << shamt_s);
            OPRN_SRA:  sc_y_s = shamt_big_s ? {W{A[W-1]}} : sra_s;
            OPRN_AND:  sc_y_s = A & B;
            OPRN_OR:   sc_y_s = A | B;
            OPRN_NOR:  sc_y_s = ~(A | B);
            OPRN_SLT:  sc_y_s = {{(W-1){1'b0}}, slt_s};
            OPRN_SLTU: sc_y_s = {{(W-1){1'b0}}, sltu_s};
            OPRN_DIVU: begin
               if (b_zero_s) begin
                  sc_y_s   = {W{1'b1}};
                  sc_hi_s  = A;
                  sc_err_s = 1'b1;
               end else begin
                  sc_y_s   = {W{1'b0}};
                  sc_hi_s  = {W{1'b0}};
                  sc_err_s = 1'b0;
               end
            end
            OPRN_MULU: sc_y_s = {W{1'b0}};
            default:   sc_err_s = 1'b1;
         endcase
      end
   end

   // Control strobes for the iterative unit.
   always_comb begin
      md_load_s   = START && (state_r == IDLE) && go_iter_s;
      md_step_s   = (state_r == ITER);
      md_is_div_s = (op_s == OPRN_DIVU);
   end

   seq_alu_muldiv #(
      .DATA_WIDTH (W)
   ) u_muldiv (
      .CLK    (CLK),
      .RST    (RST),
      .load   (md_load_s),
      .step   (md_step_s),
      .is_div (md_is_div_s),
      .A      (A),
      .B      (B),
      .hi     (md_hi_s),
      .lo     (md_lo_s)
   );

   // Sequencing FSM with registered result, status and handshake outputs.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_r <= IDLE;
         cnt_r   <= {CNT_WIDTH{1'b0}};
         y_r     <= {W{1'b0}};
         hi_r    <= {W{1'b0}};
         zero_r  <= 1'b1;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (START) begin
                  if (go_iter_s) begin
                     state_r <= ITER;
                     cnt_r   <= {CNT_WIDTH{1'b0}};
                     busy_r  <= 1'b1;
                     err_r   <= 1'b0;
                  end else begin
                     y_r    <= sc_y_s;
                     hi_r   <= sc_hi_s;
                     zero_r <= (sc_y_s == {W{1'b0}});
                     err_r  <= sc_err_s;
                     done_r <= 1'b1;
                  end
               end
            end
            ITER: begin
               // The load edge did iteration 0; leave once W-1 more are counted.
               cnt_r <= cnt_nxt_s;
               if (cnt_nxt_s == CNT_WIDTH'(W - 1)) begin
                  state_r <= FIN;
               end
            end
            FIN: begin
               y_r     <= md_lo_s;
               hi_r    <= md_hi_s;
               zero_r  <= (md_lo_s == {W{1'b0}});
               err_r   <= 1'b0;
               done_r  <= 1'b1;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign Y    = y_r;
   assign HI   = hi_r;
   assign ZERO = zero_r;
   assign BUSY = busy_r;
   assign DONE = done_r;
   assign ERR  = err_r;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (W=32): a vector table of single operations
// plus hand-written sequences for START-while-busy, back-to-back START and
// reset during a divide.
module tb_seq_alu;

   localparam int W  = 32;
   localparam int OW = 6;

   logic          CLK = 1'b0;
   logic          RST;
   logic          START;
   logic [OW-1:0] OPRN;
   logic [W-1:0]  A;
   logic [W-1:0]  B;
   logic [W-1:0]  Y;
   logic [W-1:0]  HI;
   logic          ZERO;
   logic          BUSY;
   logic          DONE;
   logic          ERR;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [OW-1:0] op;
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [W-1:0]  y;
      logic [W-1:0]  hi;
      logic          zero;
      logic          err;
      int            lat;
   } vec_t;

   vec_t vecs[24];
   int   nv = 0;

   always #5 CLK = ~CLK;

   seq_alu #(.DATA_WIDTH(W), .OPRN_WIDTH(OW)) dut (
      .CLK(CLK), .RST(RST), .START(START), .OPRN(OPRN), .A(A), .B(B),
      .Y(Y), .HI(HI), .ZERO(ZERO), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
   );

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
      end
   endtask

   task automatic add(input logic [OW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] y, input logic [W-1:0] hi,
                      input logic zero, input logic err, input int lat);
      vecs[nv] = '{op: op, a: a, b: b, y: y, hi: hi, zero: zero, err: err, lat: lat};
      nv++;
   endtask

   // Issue one operation and wait (bounded) for DONE; returns latency and
   // the number of cycles BUSY was seen high before DONE.
   task automatic run_op(input logic [OW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int busy_cnt);
      @(negedge CLK);
      START = 1'b1; OPRN = op; A = a; B = b;
      @(negedge CLK);
      START = 1'b0;
      lat = 1;
      busy_cnt = 0;
      while (DONE !== 1'b1 && lat < 100) begin
         if (BUSY === 1'b1) busy_cnt++;
         @(negedge CLK);
         lat++;
      end
   endtask

   initial begin
      int lat;
      int busy_cnt;
      int done_seen;

      //    op     A             B             Y             HI            Z     E     lat
      add(6'h01, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h00000000, 1'b0, 1'b0, 1);
      add(6'h02, 32'h00001234, 32'h00001234, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1);
      add(6'h03, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 33);
      add(6'h0B, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b0, 33);
      add(6'h0B, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b0, 1'b1, 1);
      add(6'h09, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1);
      add(6'h0A, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1);
      add(6'h0C, 32'h80000000, 32'd40,       32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1);
      add(6'h05, 32'h00000001, 32'd32,       32'h00000000, 32'h00000000, 1'b1, 1'b0, 1);
      add(6'h3F, 32'h00000005, 32'h00000006, 32'h00000000, 32'h00000000, 1'b1, 1'b1, 1);
      add(6'h04, 32'hF0000000, 32'd4,        32'h0F000000, 32'h00000000, 1'b0, 1'b0, 1);
      add(6'h08, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1);
      add(6'h06, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 32'h00000000, 1'b0, 1'b0, 1);
      add(6'h07, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 32'h00000000, 1'b0, 1'b0, 1);
      add(6'h03, 32'h12345678, 32'h00000010, 32'h23456780, 32'h00000001, 1'b0, 1'b0, 33);
      add(6'h05, 32'h00000001, 32'd31,       32'h80000000, 32'h00000000, 1'b0, 1'b0, 1);
      add(6'h0C, 32'h80000000, 32'd31,       32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1);
      add(6'h04, 32'h80000000, 32'd31,       32'h00000001, 32'h00000000, 1'b0, 1'b0, 1);
      add(6'h0B, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 32'h0000000F, 1'b0, 1'b0, 33);
      add(6'h01, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1);
      add(6'h03, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 33);
      add(6'h0A, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1);

      // Reset state
      RST = 1'b0; START = 1'b0; OPRN = '0; A = '0; B = '0;
      repeat (2) @(negedge CLK);
      check("rst.Y",    Y,             32'h0);
      check("rst.HI",   HI,            32'h0);
      check("rst.ZERO", {31'b0, ZERO}, 32'h1);
      check("rst.BUSY", {31'b0, BUSY}, 32'h0);
      check("rst.DONE", {31'b0, DONE}, 32'h0);
      check("rst.ERR",  {31'b0, ERR},  32'h0);
      RST = 1'b1;

      // Vector table
      for (int i = 0; i < nv; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, busy_cnt);
         check($sformatf("v%0d.Y", i),    Y,             vecs[i].y);
         check($sformatf("v%0d.HI", i),   HI,            vecs[i].hi);
         check($sformatf("v%0d.ZERO", i), {31'b0, ZERO}, {31'b0, vecs[i].zero});
         check($sformatf("v%0d.ERR", i),  {31'b0, ERR},  {31'b0, vecs[i].err});
         check($sformatf("v%0d.LAT", i),  32'(lat),      32'(vecs[i].lat));
         check($sformatf("v%0d.BUSYCNT", i), 32'(busy_cnt), 32'(vecs[i].lat - 1));
         check($sformatf("v%0d.BUSY_AT_DONE", i), {31'b0, BUSY}, 32'h0);
      end

      // START with ADD during the 10th MUL cycle is ignored
      @(negedge CLK);
      START = 1'b1; OPRN = 6'h03; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
      @(negedge CLK);
      START = 1'b0;
      lat = 1;
      while (DONE !== 1'b1 && lat < 100) begin
         if (lat == 10) begin
            START = 1'b1; OPRN = 6'h01; A = 32'h1; B = 32'h2;
         end else begin
            START = 1'b0;
         end
         @(negedge CLK);
         lat++;
      end
      START = 1'b0;
      check("ign.LAT", 32'(lat), 32'd33);
      check("ign.Y",   Y,        32'h00000001);
      check("ign.HI",  HI,       32'hFFFFFFFE);

      // START in the DONE cycle is accepted, DONE one cycle later
      START = 1'b1; OPRN = 6'h01; A = 32'd3; B = 32'd4;
      @(negedge CLK);
      START = 1'b0;
      check("b2b.DONE", {31'b0, DONE}, 32'h1);
      check("b2b.Y",    Y,             32'd7);
      check("b2b.BUSY", {31'b0, BUSY}, 32'h0);

      // Reset during the 5th DIV cycle
      run_op(6'h0B, 32'd5, 32'd0, lat, busy_cnt);
      check("pre.Y", Y, 32'hFFFFFFFF);
      @(negedge CLK);
      START = 1'b1; OPRN = 6'h0B; A = 32'd100; B = 32'd7;
      @(negedge CLK);
      START = 1'b0;
      lat = 1;
      while (lat < 5) begin
         @(negedge CLK);
         lat++;
      end
      check("div5.BUSY", {31'b0, BUSY}, 32'h1);
      RST = 1'b0;
      #1;
      check("arst.Y",    Y,             32'h0);
      check("arst.HI",   HI,            32'h0);
      check("arst.ZERO", {31'b0, ZERO}, 32'h1);
      check("arst.BUSY", {31'b0, BUSY}, 32'h0);
      check("arst.DONE", {31'b0, DONE}, 32'h0);
      check("arst.ERR",  {31'b0, ERR},  32'h0);
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      done_seen = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge CLK);
         if (DONE === 1'b1 || BUSY === 1'b1) done_seen++;
      end
      check("arst.NO_DONE", 32'(done_seen), 32'd0);

      // Normal operation after reset
      run_op(6'h02, 32'd10, 32'd3, lat, busy_cnt);
      check("post.Y",   Y,        32'd7);
      check("post.LAT", 32'(lat), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
